// File: rtl/mips_mc_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_ctrl_v2
// Purpose  : Multicycle MIPS control FSM with memory handshake and a
//            saturating count of discarded (illegal) instructions.
// Revision : 2.0
// ============================================================================

package mips_mc_ctrl_v2_pkg;
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } ALU_ctrl_e;
endpackage

module mips_mc_ctrl_v2
    import mips_mc_ctrl_v2_pkg::*;
#(
    parameter int EN_BNE        = 1,
    parameter int EN_JAL        = 1,
    parameter int EN_IMM_LOGIC  = 1,
    parameter int MEM_HANDSHAKE = 1,
    parameter int ILL_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic                 ZeroExt,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic [1:0]           PCSrc,
    output logic [1:0]           ALUSrcB,
    output ALU_ctrl_e            ALUControl,
    output logic                 illegal_op,
    output logic [ILL_CNT_W-1:0] illegal_cnt
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IEXEC    = 4'd9,
        S_IWB      = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12
    } state_e;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    state_e                 r_state;
    logic [ILL_CNT_W-1:0]   r_ill_cnt;

    state_e                 w_cur;
    state_e                 w_next;
    state_e                 w_dec_next;
    logic                   w_dec_legal;
    logic                   w_funct_ok;
    logic                   w_rdy;
    logic                   w_zext;
    ALU_ctrl_e              w_alu_r;
    ALU_ctrl_e              w_alu_i;

    assign w_rdy       = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign illegal_cnt = r_ill_cnt;

    // Instruction decode, independent of the current state.
    always_comb begin
        w_funct_ok = 1'b1;
        w_alu_r    = ALU_ADD;
        case (funct)
            c_FN_ADD: w_alu_r = ALU_ADD;
            c_FN_SUB: w_alu_r = ALU_SUB;
            c_FN_AND: w_alu_r = ALU_AND;
            c_FN_OR:  w_alu_r = ALU_OR;
            c_FN_SLT: w_alu_r = ALU_SLT;
            default:  w_funct_ok = 1'b0;
        endcase

        w_alu_i = ALU_ADD;
        w_zext  = 1'b0;
        case (op)
            c_OP_SLTI: w_alu_i = ALU_SLT;
            c_OP_ANDI: begin w_alu_i = ALU_AND; w_zext = 1'b1; end
            c_OP_ORI:  begin w_alu_i = ALU_OR;  w_zext = 1'b1; end
            default:   ;
        endcase

        w_dec_next = S_FETCH;
        case (op)
            c_OP_LW, c_OP_SW: w_dec_next = S_MEMADDR;
            c_OP_RTYPE:       if (w_funct_ok) w_dec_next = S_EXECUTE;
            c_OP_BEQ:         w_dec_next = S_BRANCH;
            c_OP_BNE:         if (EN_BNE != 0) w_dec_next = S_BRANCH;
            c_OP_ADDI:        w_dec_next = S_IEXEC;
            c_OP_ANDI, c_OP_ORI, c_OP_SLTI:
                              if (EN_IMM_LOGIC != 0) w_dec_next = S_IEXEC;
            c_OP_J:           w_dec_next = S_JUMP;
            c_OP_JAL:         if (EN_JAL != 0) w_dec_next = S_JAL;
            default:          ;
        endcase
        w_dec_legal = (w_dec_next != S_FETCH);
    end

    // While reset is asserted the outputs look like FETCH without any writes.
    assign w_cur = rst_n ? r_state : S_FETCH;

    always_comb begin
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ZeroExt    = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        PCSrc      = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        illegal_op = 1'b0;
        w_next     = w_cur;
        case (w_cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_rdy & rst_n;
                PCWrite = w_rdy & rst_n;
                if (w_rdy) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~w_dec_legal;
                w_next     = w_dec_next;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (w_rdy) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (w_rdy) w_next = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_alu_r;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = (op == c_OP_BNE) ? ~zero : zero;
                w_next     = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = w_alu_i;
                ZeroExt    = w_zext;
                w_next     = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                ZeroExt  = w_zext;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
                w_next  = S_FETCH;
            end
            S_JAL: begin
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
                PCSrc    = 2'b10;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ill_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (illegal_op && (r_ill_cnt != {ILL_CNT_W{1'b1}}))
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl_v2.sv
`default_nettype none
// Bench for mips_mc_ctrl_v2: instance 0 has every feature on, instance 1 has
// them all off with a 2-bit counter; both are checked against a phase model.
module tb_mips_mc_ctrl_v2;
    import mips_mc_ctrl_v2_pkg::*;

    typedef struct packed {
        logic iord, mr, mw, irw, pcw, rw, asa, zx;
        logic [1:0] rd, m2r, pcs, asb;
        logic [2:0] alu;
        logic ill;
    } outs_t;

    localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMW = 5, PEX = 6,
                   PAWB = 7, PBR = 8, PIE = 9, PIWB = 10, PJ = 11, PJAL = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic [5:0]  op_s [2];
    logic [5:0]  funct_s [2];
    outs_t       dout [2];
    logic [31:0] dcnt [2];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int plan [2][3];
    int plen [2];
    int pidx [2];
    int cnt_m [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CW = (g == 0) ? 8 : 2;
        logic iord, mr, mw, irw, pcw, rw, asa, zx, ill;
        logic [1:0] rd, m2r, pcs, asb;
        ALU_ctrl_e alu;
        logic [CW-1:0] cnt;
        mips_mc_ctrl_v2 #(
            .EN_BNE((g == 0) ? 1 : 0), .EN_JAL((g == 0) ? 1 : 0),
            .EN_IMM_LOGIC((g == 0) ? 1 : 0), .MEM_HANDSHAKE((g == 0) ? 1 : 0),
            .ILL_CNT_W(CW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .op(op_s[g]), .funct(funct_s[g]),
            .zero(zero), .mem_ready(mem_ready),
            .IorD(iord), .MemRead(mr), .MemWrite(mw), .IRWrite(irw),
            .PCWrite(pcw), .RegWrite(rw), .ALUSrcA(asa), .ZeroExt(zx),
            .RegDst(rd), .MemtoReg(m2r), .PCSrc(pcs), .ALUSrcB(asb),
            .ALUControl(alu), .illegal_op(ill), .illegal_cnt(cnt)
        );
        assign dout[g] = {iord, mr, mw, irw, pcw, rw, asa, zx, rd, m2r, pcs, asb, alu, ill};
        assign dcnt[g] = 32'(cnt);
    end

    function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s u%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endfunction

    function automatic bit full(int i);
        return i == 0;
    endfunction

    function automatic logic rdy_eff(int i);
        return full(i) ? mem_ready : 1'b1;
    endfunction

    // Phases an instruction runs through after DECODE; n==0 means discarded.
    function automatic void plan_for(input int i, input logic [5:0] o, input logic [5:0] f,
                                     output int p0, output int p1, output int p2, output int n);
        p0 = PF; p1 = PF; p2 = PF; n = 0;
        case (o)
            6'h23: begin p0 = PMA; p1 = PMR; p2 = PMWB; n = 3; end
            6'h2B: begin p0 = PMA; p1 = PMW; n = 2; end
            6'h00: if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) begin
                       p0 = PEX; p1 = PAWB; n = 2;
                   end
            6'h04: begin p0 = PBR; n = 1; end
            6'h05: if (full(i)) begin p0 = PBR; n = 1; end
            6'h08: begin p0 = PIE; p1 = PIWB; n = 2; end
            6'h0A, 6'h0C, 6'h0D: if (full(i)) begin p0 = PIE; p1 = PIWB; n = 2; end
            6'h02: begin p0 = PJ; n = 1; end
            6'h03: if (full(i)) begin p0 = PJAL; n = 1; end
            default: ;
        endcase
    endfunction

    function automatic void set_plan1(int i, int p);
        plan[i][0] = p; plen[i] = 1; pidx[i] = 0;
    endfunction

    function automatic int cur_ph(int i);
        return plan[i][pidx[i]];
    endfunction

    function automatic outs_t model_out(int i);
        outs_t e;
        int ph, p0, p1, p2, n;
        logic [5:0] o, f;
        o = op_s[i]; f = funct_s[i];
        e = '0;
        e.alu = ALU_ADD;
        ph = rst_n ? cur_ph(i) : PF;
        case (ph)
            PF:   begin e.mr = 1; e.asb = 2'b01; e.irw = rdy_eff(i) & rst_n; e.pcw = rdy_eff(i) & rst_n; end
            PD:   begin e.asb = 2'b11; plan_for(i, o, f, p0, p1, p2, n); e.ill = (n == 0); end
            PMA:  begin e.asa = 1; e.asb = 2'b10; end
            PMR:  begin e.iord = 1; e.mr = 1; end
            PMWB: begin e.m2r = 2'b01; e.rw = 1; end
            PMW:  begin e.iord = 1; e.mw = 1; end
            PEX:  begin
                e.asa = 1;
                e.alu = (f == 6'h22) ? ALU_SUB : (f == 6'h24) ? ALU_AND :
                        (f == 6'h25) ? ALU_OR  : (f == 6'h2A) ? ALU_SLT : ALU_ADD;
            end
            PAWB: begin e.rd = 2'b01; e.rw = 1; end
            PBR:  begin e.asa = 1; e.alu = ALU_SUB; e.pcs = 2'b01; e.pcw = (o == 6'h05) ? ~zero : zero; end
            PIE:  begin
                e.asa = 1; e.asb = 2'b10;
                e.alu = (o == 6'h0A) ? ALU_SLT : (o == 6'h0C) ? ALU_AND : (o == 6'h0D) ? ALU_OR : ALU_ADD;
                e.zx  = (o == 6'h0C || o == 6'h0D);
            end
            PIWB: begin e.rw = 1; e.zx = (o == 6'h0C || o == 6'h0D); end
            PJ:   begin e.pcs = 2'b10; e.pcw = 1; end
            PJAL: begin e.rd = 2'b10; e.m2r = 2'b10; e.rw = 1; e.pcs = 2'b10; e.pcw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Compare on the falling edge, then advance the model to the next cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            outs_t e;
            int ph, p0, p1, p2, n;
            e = model_out(i);
            if (chk_en) begin
                chk("outputs", i, 32'(dout[i]), 32'(e));
                chk("illegal_cnt", i, dcnt[i], cnt_m[i]);
            end
            ph = cur_ph(i);
            if (!rst_n) begin
                set_plan1(i, PF);
                cnt_m[i] = 0;
            end else begin
                if (e.ill && cnt_m[i] < (full(i) ? 255 : 3)) cnt_m[i]++;
                if ((ph == PF || ph == PMR || ph == PMW) && !rdy_eff(i)) begin
                end else if (ph == PF) begin
                    set_plan1(i, PD);
                end else if (ph == PD) begin
                    plan_for(i, op_s[i], funct_s[i], p0, p1, p2, n);
                    if (n == 0) set_plan1(i, PF);
                    else begin
                        plan[i][0] = p0; plan[i][1] = p1; plan[i][2] = p2;
                        plen[i] = n; pidx[i] = 0;
                    end
                end else begin
                    pidx[i]++;
                    if (pidx[i] >= plen[i]) set_plan1(i, PF);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic rdy, input logic z, input logic [5:0] o, input logic [5:0] f);
        @(posedge clk); #1;
        rst_n = r; mem_ready = rdy; zero = z;
        op_s[0] = o; op_s[1] = o; funct_s[0] = f; funct_s[1] = f;
        #1;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [12];
        int k;
        tbl = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h03, 6'h3F};
        k = $urandom_range(0, 12);
        return (k == 12) ? 6'($urandom_range(0, 63)) : tbl[k];
    endfunction

    function automatic logic [5:0] pick_funct();
        logic [5:0] tbl [6];
        int k;
        tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        k = $urandom_range(0, 6);
        return (k == 6) ? 6'($urandom_range(0, 63)) : tbl[k];
    endfunction

    initial begin
        int sat_exp [5];
        logic lw_rdy [11];
        sat_exp = '{1, 2, 3, 3, 3};
        lw_rdy  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            set_plan1(i, PF); cnt_m[i] = 0;
            op_s[i] = 6'h23; funct_s[i] = 6'h20;
        end
        repeat (2) @(posedge clk);
        #2;
        chk("rst_memread", 0, dout[0].mr, 1);
        chk("rst_irwrite", 0, dout[0].irw, 0);
        chk("rst_alusrcb", 0, dout[0].asb, 2'b01);
        chk("rst_cnt", 0, dcnt[0], 0);
        chk_en = 1'b1;

        // LW with fetch and read waits: 10 cycles, then back to FETCH.
        for (int c = 0; c < 11; c++) begin
            cyc(1, lw_rdy[c], 0, 6'h23, 6'h20);
            if (c < 4) chk("lw_fetch_irwrite", 0, dout[0].irw, (c == 3));
            if (c < 4) chk("lw_fetch_pcwrite", 0, dout[0].pcw, (c == 3));
            if (c >= 6 && c <= 8) chk("lw_memread_iord", 0, dout[0].iord, 1);
            if (c == 9) chk("lw_memwb_regwrite", 0, dout[0].rw, 1);
            if (c == 9) chk("lw_memwb_memtoreg", 0, dout[0].m2r, 2'b01);
            if (c == 10) chk("lw_back_fetch", 0, {dout[0].iord, dout[0].mr}, 2'b01);
        end

        // BEQ taken, BNE not taken, BNE illegal on the reduced instance.
        cyc(0, 1, 0, 6'h04, 0); cyc(1, 1, 1, 6'h04, 0); cyc(1, 1, 1, 6'h04, 0);
        cyc(1, 1, 1, 6'h04, 0);
        chk("beq_pcwrite", 0, dout[0].pcw, 1);
        chk("beq_pcsrc", 0, dout[0].pcs, 2'b01);
        cyc(0, 1, 0, 6'h05, 0); cyc(1, 1, 1, 6'h05, 0);
        cyc(1, 1, 1, 6'h05, 0);
        chk("bne_off_illegal_op", 1, dout[1].ill, 1);
        cyc(1, 1, 1, 6'h05, 0);
        chk("bne_pcwrite", 0, dout[0].pcw, 0);
        chk("bne_off_cnt", 1, dcnt[1], 1);

        // JAL writes link and PC together, then FETCH.
        cyc(0, 1, 0, 6'h03, 0); cyc(1, 1, 0, 6'h03, 0); cyc(1, 1, 0, 6'h03, 0);
        cyc(1, 1, 0, 6'h03, 0);
        chk("jal_ctrl", 0, {dout[0].rd, dout[0].m2r, dout[0].rw, dout[0].pcw, dout[0].pcs}, 8'b10_10_1_1_10);
        cyc(1, 1, 0, 6'h03, 0);
        chk("jal_back_fetch", 0, {dout[0].mr, dout[0].irw}, 2'b11);

        // ORI zero-extends through IEXEC and IWB.
        cyc(0, 1, 0, 6'h0D, 0); cyc(1, 1, 0, 6'h0D, 0); cyc(1, 1, 0, 6'h0D, 0);
        cyc(1, 1, 0, 6'h0D, 0);
        chk("ori_alu", 0, dout[0].alu, ALU_OR);
        chk("ori_zeroext", 0, dout[0].zx, 1);
        cyc(1, 1, 0, 6'h0D, 0);
        chk("ori_iwb", 0, {dout[0].rw, dout[0].rd, dout[0].zx}, 4'b1_00_1);

        // Five illegal instructions saturate the 2-bit counter.
        cyc(0, 1, 0, 6'h3F, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 0, (k % 2 == 0) ? 6'h3F : 6'h00, 0);
            if (k > 0) chk("sat_cnt", 1, dcnt[1], sat_exp[k-1]);
            cyc(1, 1, 0, (k % 2 == 0) ? 6'h3F : 6'h00, 0);
        end
        cyc(1, 1, 0, 6'h2B, 0);
        chk("sat_cnt", 1, dcnt[1], sat_exp[4]);

        // Reset in the middle of a SW memory wait.
        cyc(1, 1, 0, 6'h2B, 0); cyc(1, 1, 0, 6'h2B, 0); cyc(1, 0, 0, 6'h2B, 0);
        cyc(1, 0, 0, 6'h2B, 0);
        chk("sw_wait_memwrite", 0, {dout[0].iord, dout[0].mw}, 2'b11);
        chk("sw_cnt_before_rst", 0, dcnt[0], 5);
        cyc(0, 0, 0, 6'h2B, 0);
        chk("rst_in_sw_memwrite", 0, dout[0].mw, 0);
        cyc(1, 0, 0, 6'h2B, 0);
        chk("after_rst_fetch", 0, {dout[0].mr, dout[0].mw, dout[0].irw}, 3'b100);
        chk("after_rst_cnt", 0, dcnt[0], 0);

        // Random traffic; instruction fields only change while a model is in FETCH.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst_n     = ($urandom_range(0, 199) != 0);
            mem_ready = ($urandom_range(0, 9) < 7);
            zero      = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                if (cur_ph(i) == PF) begin
                    op_s[i]    = pick_op();
                    funct_s[i] = pick_funct();
                end
            end
        end
        @(posedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
